// File: rtl/cr_huf_comp_ob_ftr_patch.sv
// cr_huf_comp_ob_ftr_patch
//
// Sits between the Huffman compressor output and the output fabric. It counts
// the valid payload bytes of every DATA TLV in a frame and writes that count
// into bits [43:20] of the last word of the frame's FTR TLV. The AXI4-S path
// is re-timed through a 2-entry skid buffer, so every output is a flop.
//
// Ports:
//   clk, rst         core clock, synchronous active-high reset
//   in_t*            upstream AXI4-S slave (tuser bit0 = SoT, bit1 = EoT)
//   out_t*           downstream AXI4-S master (registered)
//   frame_bytes      byte count of the last closed frame
//   frame_bytes_vld  one-cycle pulse whenever frame_bytes updates
//   cnt_ovf          sticky flag, count saturated since the last reset
module cr_huf_comp_ob_ftr_patch #(
  parameter int         DATA_W    = 64,
  parameter int         USER_W    = 8,
  parameter logic [7:0] DATA_TYPE = 8'h03,
  parameter logic [7:0] FTR_TYPE  = 8'h08,
  parameter int         CNT_W     = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_tvalid,
  output logic                in_tready,
  input  logic [DATA_W-1:0]   in_tdata,
  input  logic [USER_W-1:0]   in_tuser,
  input  logic [DATA_W/8-1:0] in_tstrb,
  input  logic                in_tlast,
  input  logic                in_tid,
  output logic                out_tvalid,
  input  logic                out_tready,
  output logic [DATA_W-1:0]   out_tdata,
  output logic [USER_W-1:0]   out_tuser,
  output logic [DATA_W/8-1:0] out_tstrb,
  output logic                out_tlast,
  output logic                out_tid,
  output logic [CNT_W-1:0]    frame_bytes,
  output logic                frame_bytes_vld,
  output logic                cnt_ovf
);

  localparam int STRB_W = DATA_W / 8;
  // Buffered word layout: {tdata, tuser, tstrb, tlast, tid}
  localparam int WORD_W = DATA_W + USER_W + STRB_W + 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_IN_DATA,
    ST_IN_FTR,
    ST_IN_OTHER
  } parse_state_e;

  parse_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  fb_q, fb_d;
  logic              fbv_q, fbv_d;
  logic [1:0]        occ_q, occ_d;
  logic              in_tready_q, in_tready_d;
  logic              out_tvalid_q, out_tvalid_d;
  logic [WORD_W-1:0] head_q, head_d;
  logic [WORD_W-1:0] skid_q, skid_d;

  logic              push, pop, sot, eot;
  logic [7:0]        tlv_type;
  logic [CNT_W:0]    strb_cnt, add_sum;
  logic [DATA_W-1:0] patched_data;
  logic [WORD_W-1:0] in_word;

  assign push     = in_tvalid & in_tready_q;
  assign pop      = out_tvalid_q & out_tready;
  assign sot      = in_tuser[0];
  assign eot      = in_tuser[1];
  assign tlv_type = in_tdata[7:0];

  // Number of valid byte lanes on the incoming word; the extra top bit of the
  // sum is the saturation detector.
  always_comb begin
    strb_cnt = '0;
    for (int i = 0; i < STRB_W; i++) begin
      strb_cnt = strb_cnt + (CNT_W+1)'(in_tstrb[i]);
    end
    add_sum = {1'b0, cnt_q} + strb_cnt;
  end

  // Parser: tracks which TLV type is open, accumulates DATA payload bytes and
  // closes the frame on the last word of the FTR TLV. The count is inserted
  // into the footer word before it enters the skid buffer, so downstream sees
  // the patched word with the same latency as any other word.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ovf_d        = ovf_q;
    fb_d         = fb_q;
    fbv_d        = 1'b0;
    patched_data = in_tdata;
    if (push) begin
      if (sot) begin
        // Header word, never counted; also restarts parsing after a missing EoT
        if (eot)                        state_d = ST_IDLE;
        else if (tlv_type == DATA_TYPE) state_d = ST_IN_DATA;
        else if (tlv_type == FTR_TYPE)  state_d = ST_IN_FTR;
        else                            state_d = ST_IN_OTHER;
      end else begin
        if (state_q == ST_IN_DATA) begin
          if (add_sum[CNT_W]) begin
            cnt_d = '1;
            ovf_d = 1'b1;
          end else begin
            cnt_d = add_sum[CNT_W-1:0];
          end
        end
        if (state_q == ST_IN_FTR && eot) begin
          patched_data[43:20] = 24'(cnt_q);
          fb_d                = cnt_q;
          fbv_d               = 1'b1;
          cnt_d               = '0;
        end
        if (eot) state_d = ST_IDLE;
      end
    end
  end

  assign in_word = {patched_data, in_tuser, in_tstrb, in_tlast, in_tid};

  // Skid buffer: head_q drives the outputs, skid_q holds the second word when
  // downstream stalls. A word goes straight to the head if the head is free or
  // is being consumed this cycle.
  always_comb begin
    head_d = head_q;
    skid_d = skid_q;
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
    if (push && (occ_q == 2'd0 || pop)) head_d = in_word;
    else if (push)                      skid_d = in_word;
    else if (pop && occ_q == 2'd2)      head_d = skid_q;
    out_tvalid_d = (occ_d != 2'd0);
    in_tready_d  = (occ_d != 2'd2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      fb_q         <= '0;
      fbv_q        <= 1'b0;
      occ_q        <= 2'd0;
      in_tready_q  <= 1'b0;
      out_tvalid_q <= 1'b0;
      head_q       <= '0;
      skid_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      fb_q         <= fb_d;
      fbv_q        <= fbv_d;
      occ_q        <= occ_d;
      in_tready_q  <= in_tready_d;
      out_tvalid_q <= out_tvalid_d;
      head_q       <= head_d;
      skid_q       <= skid_d;
    end
  end

  assign in_tready       = in_tready_q;
  assign out_tvalid      = out_tvalid_q;
  assign out_tdata       = head_q[WORD_W-1 -: DATA_W];
  assign out_tuser       = head_q[USER_W+STRB_W+1 -: USER_W];
  assign out_tstrb       = head_q[STRB_W+1 -: STRB_W];
  assign out_tlast       = head_q[1];
  assign out_tid         = head_q[0];
  assign frame_bytes     = fb_q;
  assign frame_bytes_vld = fbv_q;
  assign cnt_ovf         = ovf_q;

endmodule

// File: doc/cr_huf_comp_ob_ftr_patch.md
Name: cr_huf_comp_ob_ftr_patch

Overview:
- Sits directly downstream of the Huffman compressor output (huf_comp_ob_out) and upstream of the output fabric.
- Counts the valid compressed payload bytes of DATA TLVs per frame.
- Patches the 24-bit count into the last word of the frame's FTR TLV.
- Re-times the AXI4-S datapath through a 2-entry skid buffer, so all outputs are registered.

Parameters:
- DATA_W, 64, tdata width (byte lanes = DATA_W/8).
- USER_W, 8, tuser width; bit0 = start-of-TLV (SoT), bit1 = end-of-TLV (EoT).
- DATA_TYPE, 8'h03, TLV type code of DATA TLV (tdata[7:0] on SoT word).
- FTR_TYPE, 8'h08, TLV type code of FTR TLV.
- CNT_W, 24, byte-count width.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- in_tvalid  in  1  upstream valid
- in_tready  out  1  upstream ready
- in_tdata  in  DATA_W  upstream data
- in_tuser  in  USER_W  upstream user (SoT/EoT)
- in_tstrb  in  DATA_W/8  byte-lane strobes
- in_tlast  in  1  frame last
- in_tid  in  1  stream id
- out_tvalid  out  1  downstream valid
- out_tready  in  1  downstream ready
- out_tdata  out  DATA_W  downstream data
- out_tuser  out  USER_W  downstream user
- out_tstrb  out  DATA_W/8  downstream strobes
- out_tlast  out  1  downstream last
- out_tid  out  1  downstream id
- frame_bytes  out  CNT_W  count latched at FTR EoT
- frame_bytes_vld  out  1  1-cycle pulse when frame_bytes updates
- cnt_ovf  out  1  sticky: count saturated in the current or a previous frame

Behaviour:
Reset:
- One clock; rst is synchronous, active-high.
- At reset: out_tvalid=0, in_tready=0 during rst and 1 the cycle after, all out_* data=0, frame_bytes=0, frame_bytes_vld=0, cnt_ovf=0, counter=0, parse state=IDLE, buffer empty.
- rst mid-frame discards buffered words and the partial count. No output asserted in the cycle rst is high.

Skid buffer:
- 2 entries. in_tready = (occupancy < 2), registered.
- Accept when in_tvalid & in_tready.
- Latency: in-to-out is 1 cycle when the buffer is empty.
- out_* are stable while out_tvalid & !out_tready.
- Ordering is preserved. Simultaneous push and pop at occupancy 2 is impossible because in_tready=0; at occupancy 1 it leaves occupancy at 1.

Parser FSM:
- Advances only on accepted input words. States: IDLE, IN_DATA, IN_FTR, IN_OTHER.
- SoT word: type==DATA_TYPE -> IN_DATA; type==FTR_TYPE -> IN_FTR; otherwise IN_OTHER. The SoT header word is never counted.
- SoT & EoT on the same word: state returns to IDLE and nothing is counted.
- IN_DATA non-SoT words: counter += popcount(in_tstrb).
- Saturation: if the sum exceeds 2^CNT_W-1, counter holds at all-ones and cnt_ovf is set. cnt_ovf clears only on rst.
- Any EoT word -> IDLE.
- A SoT arriving while not IDLE (protocol error) restarts parsing on that word; the counter is kept.

Footer patch:
- Applies to the accepted word with state IN_FTR, EoT=1, SoT=0.
- tdata[43:20] is replaced by the counter value, including any count added by the same word (always 0, since FTR is not counted).
- All other bits pass unmodified. The patch is applied before the word enters the buffer.
- On the same accept: frame_bytes <= counter, frame_bytes_vld pulses for 1 cycle, and the counter is cleared to 0 for the next frame.
- A frame with no DATA TLV is patched with 0.

Passthrough:
- tuser, tstrb, tlast and tid pass unchanged.
- tlast has no effect on counting; only the FTR EoT closes a frame.

Test Plan:
- DATA TLV: header plus 3 words with tstrb FF, FF, 0F, then FTR of 2 words with EoT on the 2nd and tdata=64'hFFFF_FFFF_FFFF_FFFF -> patched tdata=64'hFFFF_F000_014F_FFFF (0x14=20 in [43:20]), frame_bytes=20, one vld pulse, out_tready=1, 1-cycle latency.
- Two DATA TLVs (10 bytes + 6 bytes) before FTR -> footer field=16. A following frame with no DATA -> field=0 and counter restarted.
- Backpressure: out_tready=0 for 5 cycles mid-stream -> in_tready drops after 2 accepted words, no loss or duplication, out_* stable while stalled, order intact.
- Saturation with CNT_W=8: 33 DATA words with tstrb=FF (264 bytes) -> footer field=0xFF, cnt_ovf=1 held across the next frame.
- Non-DATA TLV (type 8'h01) of 4 words with tstrb=FF between DATA words -> not counted.
- SoT+EoT single-word DATA -> 0 counted.
- rst asserted mid DATA TLV with 1 word buffered -> next cycle out_tvalid=0. After a fresh frame, the footer holds only that frame's count.
